chip8_arith_sequencer: RTL

//   Executes one CHIP-8 8XYN arithmetic/logic opcode per start.

---
 rtl/chip8_arith_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/chip8_arith_sequencer.sv
// chip8_arith_sequencer: runs one CHIP-8 8XYN ALU opcode (read Vx/Vy, execute, write Vx then VF); CHIP8_VF_RESET_EN makes ops 1-3 clear VF
module chip8_arith_sequencer #(
  parameter int          DATA_W   = 8,
  parameter logic [3:0]  FLAG_REG = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       opcode,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [3:0]        reg_addr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry
);
  typedef enum logic [2:0] {IDLE, RDX, RDY, EXE, WBR, WBF, FIN} state_t;
  state_t            state_q, state_d;
  logic [15:0]       op_q, op_d;
  logic [DATA_W-1:0] vx_q, vx_d, vy_q, vy_d, res_q, res_d;
  logic              flag_q, flag_d, err_q, err_d;
  logic [3:0]        n, x, y;
  logic              legal, wbf, swap, flag;
  logic [DATA_W-1:0] vy_eff;
  assign n      = op_q[3:0];
  assign x      = op_q[11:8];
  assign y      = op_q[7:4];
  assign legal  = (op_q[15:12] == 4'h8) && (!n[3] || n == 4'hE);
`ifdef CHIP8_VF_RESET_EN
  assign wbf    = n == 4'hE || (!n[3] && n != 4'h0);
`else
  assign wbf    = n == 4'hE || (!n[3] && n[2]);
`endif
  // Vy arrives on reg_rdata during EXE, so the ALU sees it straight away and the result is latched at the end of EXE
  assign vy_eff = state_q == EXE ? reg_rdata : vy_q;
  assign swap   = n == 4'h7;
  assign alu_x  = swap ? vy_eff : vx_q;
  assign alu_y  = swap ? vx_q : vy_eff;
  assign alu_op = n == 4'hE ? 3'd7 : swap ? 3'd5 : n[2:0];
  assign flag   = n == 4'h6 ? vx_q[0] : n == 4'hE ? vx_q[DATA_W-1] : n[2] ? alu_carry : 1'b0;
  assign err    = err_q;
  // State register and operand/result latches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end
  // Sequencing and register-file port; legality is decided from the latched opcode in RDX
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    res_d     = res_q;
    flag_d    = flag_q;
    err_d     = err_q;
    ready     = 1'b0;
    done      = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          op_d    = opcode;
          err_d   = 1'b0;
          state_d = RDX;
        end
      end
      RDX: begin
        reg_addr = x;
        err_d    = !legal;
        state_d  = legal ? RDY : FIN;
      end
      RDY: begin
        reg_addr = y;
        vx_d     = reg_rdata;
        state_d  = EXE;
      end
      EXE: begin
        vy_d    = reg_rdata;
        res_d   = alu_out;
        flag_d  = flag;
        state_d = WBR;
      end
      WBR: begin
        reg_we    = 1'b1;
        reg_addr  = x;
        reg_wdata = res_q;
        state_d   = wbf ? WBF : FIN;
      end
      WBF: begin
        reg_we    = 1'b1;
        reg_addr  = FLAG_REG;
        reg_wdata = {{(DATA_W-1){1'b0}}, flag_q};
        state_d   = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
